// File: rtl/sdram_line_reader.sv
// Streams one video line from SDRAM over Avalon-MM into a byte-wide VGA line FIFO.
// Reads are credit-limited so that every read in flight always has a slot in the word buffer.
module sdram_line_reader #(
    parameter int WORDS_PER_LINE = 512,
    parameter int MAX_PENDING    = 8
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iLOAD_REQ,
    input  logic [12:0] iLINE,
    input  logic [24:0] iFRAME_BASE,
    output logic        oRD_EN,
    output logic [24:0] oRD_ADDR,
    input  logic        iWAIT_REQUEST,
    input  logic [15:0] iRD_DATA,
    input  logic        iRD_DATAVALID,
    output logic [7:0]  oWDATA,
    output logic        oWEN,
    input  logic        iFIFO_FULL,
    output logic        oBUSY,
    output logic        oDONE,
    output logic        oMISSED
);

    localparam int CW = $clog2(WORDS_PER_LINE + 1);
    localparam int PW = $clog2(MAX_PENDING + 1);
    localparam int AW = $clog2(MAX_PENDING);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    localparam logic [CW-1:0] LP_WORDS  = CW'(WORDS_PER_LINE);
    localparam logic [PW:0]   LP_CREDIT = (PW + 1)'(MAX_PENDING);

    logic [1:0]    r_state;
    logic [24:0]   r_addr;
    logic [CW-1:0] r_issued;
    logic [PW-1:0] r_pending;
    logic [PW-1:0] r_count;
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic          r_byte_sel;
    logic          r_busy;
    logic          r_done;
    logic          r_missed;
    logic [15:0]   r_buf [MAX_PENDING];

    logic [24:0]   w_line_off;
    logic [24:0]   w_start;
    logic          w_active;
    logic          w_credit;
    logic          w_rd_en;
    logic          w_accept;
    logic          w_push;
    logic          w_pop;
    logic          w_pop_word;
    logic          w_done_now;
    logic [15:0]   w_head;

    assign w_line_off = {12'd0, iLINE} * 25'(WORDS_PER_LINE);
    assign w_start    = iFRAME_BASE + w_line_off;
    assign w_active   = (r_state != ST_IDLE);

    // Buffered words count against the credit too, so the buffer can never overflow.
    assign w_credit   = ({1'b0, r_pending} + {1'b0, r_count}) < LP_CREDIT;
    assign w_rd_en    = (r_state == ST_READ) && (r_issued < LP_WORDS) && w_credit;
    assign w_accept   = w_rd_en && !iWAIT_REQUEST;
    assign w_push     = iRD_DATAVALID && w_active && (r_pending != '0);
    assign w_pop      = w_active && (r_count != '0) && !iFIFO_FULL;
    assign w_pop_word = w_pop && r_byte_sel;
    assign w_done_now = w_pop_word && (r_issued == LP_WORDS) && (r_pending == '0)
                        && (r_count == PW'(1)) && !w_push;
    assign w_head     = r_buf[r_rptr];

    assign oRD_EN   = w_rd_en;
    assign oRD_ADDR = r_addr;
    assign oWEN     = w_pop;
    assign oWDATA   = (w_active && r_count != '0) ? (r_byte_sel ? w_head[15:8] : w_head[7:0]) : 8'h00;
    assign oBUSY    = r_busy;
    assign oDONE    = r_done;
    assign oMISSED  = r_missed;

    // NOTE: the word buffer is deliberately not reset; r_count gates every read of it.
    always_ff @(posedge iCLK) begin
        if (w_push) begin
            r_buf[r_wptr] <= iRD_DATA;
        end
    end

    // NOTE: state uses non-blocking assignments only, so every branch sees pre-edge values.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_state    <= ST_IDLE;
            r_addr     <= '0;
            r_issued   <= '0;
            r_pending  <= '0;
            r_count    <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_byte_sel <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_missed   <= 1'b0;
        end else begin
            r_done   <= 1'b0;
            r_missed <= iLOAD_REQ && (r_busy || r_done);
            if (r_state == ST_IDLE) begin
                if (iLOAD_REQ && !r_done) begin
                    r_state    <= ST_READ;
                    r_addr     <= w_start;
                    r_issued   <= '0;
                    r_pending  <= '0;
                    r_count    <= '0;
                    r_wptr     <= '0;
                    r_rptr     <= '0;
                    r_byte_sel <= 1'b0;
                    r_busy     <= 1'b1;
                end
            end else begin
                r_issued  <= r_issued + CW'(w_accept);
                r_pending <= r_pending + PW'(w_accept) - PW'(w_push);
                r_count   <= r_count + PW'(w_push) - PW'(w_pop_word);
                if (w_accept) begin
                    r_addr <= r_addr + 25'd1;
                end
                if (w_push) begin
                    r_wptr <= r_wptr + AW'(1);
                end
                if (w_pop_word) begin
                    r_rptr <= r_rptr + AW'(1);
                end
                if (w_pop) begin
                    r_byte_sel <= ~r_byte_sel;
                end
                if (w_done_now) begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end else if (r_state == ST_READ && r_issued == LP_WORDS) begin
                    r_state <= ST_FLUSH;
                end
            end
        end
    end

endmodule

// File: tb/tb_sdram_line_reader.sv
// Bench for sdram_line_reader: Avalon slave with 2-cycle read latency, random data,
// and a line model that predicts every address and byte from the frame base and line index.
module tb_sdram_line_reader;

    localparam int W  = 512;
    localparam int MP = 8;

    logic        iCLK = 1'b0;
    logic        iRST;
    logic        iLOAD_REQ;
    logic [12:0] iLINE;
    logic [24:0] iFRAME_BASE;
    logic        oRD_EN;
    logic [24:0] oRD_ADDR;
    logic        iWAIT_REQUEST;
    logic [15:0] iRD_DATA;
    logic        iRD_DATAVALID;
    logic [7:0]  oWDATA;
    logic        oWEN;
    logic        iFIFO_FULL;
    logic        oBUSY;
    logic        oDONE;
    logic        oMISSED;

    sdram_line_reader #(.WORDS_PER_LINE(W), .MAX_PENDING(MP)) dut (
        .iCLK(iCLK), .iRST(iRST), .iLOAD_REQ(iLOAD_REQ), .iLINE(iLINE),
        .iFRAME_BASE(iFRAME_BASE), .oRD_EN(oRD_EN), .oRD_ADDR(oRD_ADDR),
        .iWAIT_REQUEST(iWAIT_REQUEST), .iRD_DATA(iRD_DATA), .iRD_DATAVALID(iRD_DATAVALID),
        .oWDATA(oWDATA), .oWEN(oWEN), .iFIFO_FULL(iFIFO_FULL), .oBUSY(oBUSY),
        .oDONE(oDONE), .oMISSED(oMISSED)
    );

    always #5 iCLK = ~iCLK;

    typedef struct {
        logic [24:0] addr;
        int          due;
    } rd_t;

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          done_cnt;
    int          missed_cnt;
    logic [31:0] data_seed = 32'h1234_5678;
    logic        dir_wait, dir_full, hold_valid, stray, rand_mode;
    logic        rnd_wait = 1'b0, rnd_full = 1'b0, rnd_hold = 1'b0;
    logic        prev_stall = 1'b0, prev_rst = 1'b1;
    logic [24:0] prev_addr = '0;
    rd_t         pipe[$];
    logic [24:0] exp_addr[$], got_addr[$];
    logic [7:0]  exp_byte[$], got_byte[$];

    assign iWAIT_REQUEST = rand_mode ? rnd_wait : dir_wait;
    assign iFIFO_FULL    = rand_mode ? rnd_full : dir_full;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] mem_word(input logic [24:0] a);
        logic [31:0] h;
        h = ({7'd0, a} * 32'h9E37_79B1) ^ data_seed;
        return h[23:8];
    endfunction

    // Avalon slave: answers each accepted read two cycles later unless data is withheld.
    always @(posedge iCLK) begin
        cyc++;
        #1;
        rnd_wait = 1'($urandom_range(0, 1));
        rnd_full = ($urandom_range(0, 3) == 0);
        rnd_hold = ($urandom_range(0, 3) == 0);
        if (stray) begin
            iRD_DATAVALID = 1'b1;
            iRD_DATA      = 16'hDEAD;
        end else if (pipe.size() > 0 && pipe[0].due <= cyc && !hold_valid && !(rand_mode && rnd_hold)) begin
            iRD_DATAVALID = 1'b1;
            iRD_DATA      = mem_word(pipe[0].addr);
            void'(pipe.pop_front());
        end else begin
            iRD_DATAVALID = 1'b0;
            iRD_DATA      = 16'($urandom);
        end
    end

    // Mid-cycle monitor: records accepted reads and FIFO writes, checks stall stability.
    always @(negedge iCLK) begin
        if (oRD_EN && !iWAIT_REQUEST) begin
            got_addr.push_back(oRD_ADDR);
            pipe.push_back('{addr: oRD_ADDR, due: cyc + 2});
        end
        if (oWEN) got_byte.push_back(oWDATA);
        if (oDONE) done_cnt++;
        if (oMISSED) missed_cnt++;
        if (prev_stall && !prev_rst) begin
            check("rd_hold_en", 32'(oRD_EN), 32'd1);
            check("rd_hold_addr", 32'(oRD_ADDR), 32'(prev_addr));
        end
        prev_stall = oRD_EN && iWAIT_REQUEST;
        prev_addr  = oRD_ADDR;
        prev_rst   = iRST;
        if (iRST) pipe.delete();
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge iCLK);
            #1;
        end
    endtask

    task automatic begin_load(input logic [24:0] base, input logic [12:0] line);
        longint s;
        data_seed = $urandom;
        s = (longint'(base) + longint'(line) * W) % 64'h200_0000;
        exp_addr.delete();
        exp_byte.delete();
        for (int k = 0; k < W; k++) begin
            logic [24:0] a;
            logic [15:0] d;
            a = 25'((s + k) % 64'h200_0000);
            d = mem_word(a);
            exp_addr.push_back(a);
            exp_byte.push_back(d[7:0]);
            exp_byte.push_back(d[15:8]);
        end
        got_addr.delete();
        got_byte.delete();
        done_cnt    = 0;
        missed_cnt  = 0;
        iFRAME_BASE = base;
        iLINE       = line;
        iLOAD_REQ   = 1'b1;
        step(1);
        iLOAD_REQ   = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (oDONE !== 1'b1 && n < budget) begin
            step(1);
            n++;
        end
        check({tag, "_done_seen"}, 32'(oDONE), 32'd1);
    endtask

    task automatic wait_bytes(input string tag, input int nb, input int budget);
        int n = 0;
        while (got_byte.size() < nb && n < budget) begin
            step(1);
            n++;
        end
        check({tag, "_bytes_reached"}, 32'(got_byte.size() >= nb), 32'd1);
    endtask

    task automatic end_load(input string tag, input int exp_missed);
        int na, nb;
        step(1);
        check({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
        check({tag, "_done_low"}, 32'(oDONE), 32'd0);
        check({tag, "_busy_low"}, 32'(oBUSY), 32'd0);
        check({tag, "_rd_en_low"}, 32'(oRD_EN), 32'd0);
        check({tag, "_missed"}, 32'(missed_cnt), 32'(exp_missed));
        check({tag, "_n_addr"}, 32'(got_addr.size()), 32'(W));
        check({tag, "_n_bytes"}, 32'(got_byte.size()), 32'(2 * W));
        na = (got_addr.size() < W) ? got_addr.size() : W;
        nb = (got_byte.size() < 2 * W) ? got_byte.size() : 2 * W;
        for (int i = 0; i < na; i++) check({tag, "_addr"}, 32'(got_addr[i]), 32'(exp_addr[i]));
        for (int i = 0; i < nb; i++) check({tag, "_byte"}, 32'(got_byte[i]), 32'(exp_byte[i]));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rd_en"}, 32'(oRD_EN), 32'd0);
        check({tag, "_rd_addr"}, 32'(oRD_ADDR), 32'd0);
        check({tag, "_wen"}, 32'(oWEN), 32'd0);
        check({tag, "_wdata"}, 32'(oWDATA), 32'd0);
        check({tag, "_busy"}, 32'(oBUSY), 32'd0);
        check({tag, "_done"}, 32'(oDONE), 32'd0);
        check({tag, "_missed"}, 32'(oMISSED), 32'd0);
    endtask

    initial begin
        int nb;
        iRST = 1'b1; iLOAD_REQ = 1'b0; iLINE = '0; iFRAME_BASE = '0;
        dir_wait = 1'b0; dir_full = 1'b0; hold_valid = 1'b0; stray = 1'b0; rand_mode = 1'b0;
        iRD_DATA = '0; iRD_DATAVALID = 1'b0;
        step(3);
        check_all_zero("reset");
        iRST = 1'b0;
        step(2);

        // Stray readdatavalid while idle must not reach the FIFO.
        got_byte.delete();
        stray = 1'b1;
        step(3);
        stray = 1'b0;
        step(2);
        check("idle_stray_wen", 32'(got_byte.size()), 32'd0);
        check("idle_stray_busy", 32'(oBUSY), 32'd0);

        // Base load, then a request landing on the oDONE cycle.
        begin_load(25'd0, 13'd3);
        check("base_busy", 32'(oBUSY), 32'd1);
        wait_done("base", 8000);
        iLOAD_REQ = 1'b1;
        step(1);
        iLOAD_REQ = 1'b0;
        @(negedge iCLK);
        check("done_req_missed", 32'(oMISSED), 32'd1);
        check("done_req_busy", 32'(oBUSY), 32'd0);
        @(posedge iCLK); #1;
        end_load("base", 1);
        check("base_first_addr", 32'(got_addr[0]), 32'd1536);
        check("base_last_addr", 32'(got_addr[W-1]), 32'd2047);

        // Five wait states on the first read.
        dir_wait = 1'b1;
        begin_load(25'd0, 13'd3);
        for (int i = 0; i < 5; i++) begin
            @(negedge iCLK);
            check("wait_rd_en", 32'(oRD_EN), 32'd1);
            check("wait_rd_addr", 32'(oRD_ADDR), 32'd1536);
            @(posedge iCLK); #1;
        end
        dir_wait = 1'b0;
        check("wait_no_accept", 32'(got_addr.size()), 32'd0);
        wait_done("wait", 8000);
        end_load("wait", 0);

        // Credit limit with read data withheld.
        hold_valid = 1'b1;
        begin_load(25'h000_0400, 13'd10);
        step(20);
        check("credit_accepted", 32'(got_addr.size()), 32'(MP));
        @(negedge iCLK);
        check("credit_rd_en", 32'(oRD_EN), 32'd0);
        check("credit_wen", 32'(oWEN), 32'd0);
        @(posedge iCLK); #1;
        hold_valid = 1'b0;
        wait_done("credit", 8000);
        end_load("credit", 0);

        // FIFO full for ten cycles mid-line.
        begin_load(25'($urandom), 13'($urandom));
        wait_bytes("full", 200, 4000);
        dir_full = 1'b1;
        nb = got_byte.size();
        for (int i = 0; i < 10; i++) begin
            @(negedge iCLK);
            check("full_wen", 32'(oWEN), 32'd0);
            if (i >= 3) check("full_wdata_held", 32'(oWDATA), 32'(exp_byte[nb]));
            @(posedge iCLK); #1;
        end
        dir_full = 1'b0;
        check("full_no_writes", 32'(got_byte.size()), 32'(nb));
        wait_done("full", 8000);
        end_load("full", 0);

        // Address wrap plus an ignored request mid-load.
        begin_load(25'h1FF_FF00, 13'd0);
        step(50);
        iFRAME_BASE = 25'h000_0123;
        iLINE       = 13'd7;
        iLOAD_REQ   = 1'b1;
        step(1);
        iLOAD_REQ   = 1'b0;
        @(negedge iCLK);
        check("busy_req_missed", 32'(oMISSED), 32'd1);
        check("busy_req_busy", 32'(oBUSY), 32'd1);
        @(posedge iCLK); #1;
        wait_done("wrap", 8000);
        end_load("wrap", 1);
        check("wrap_top", 32'(got_addr[255]), 32'h1FF_FFFF);
        check("wrap_zero", 32'(got_addr[256]), 32'd0);

        // Reset mid-load, then a clean load.
        begin_load(25'($urandom), 13'($urandom));
        wait_bytes("rst", 100, 4000);
        iRST = 1'b1;
        step(1);
        check_all_zero("mid_reset");
        iRST = 1'b0;
        step(5);
        check("rst_no_done", 32'(done_cnt), 32'd0);
        check("rst_idle_busy", 32'(oBUSY), 32'd0);
        begin_load(25'($urandom), 13'($urandom));
        wait_done("after_rst", 8000);
        end_load("after_rst", 0);

        // Random waitrequest, FIFO full and data-return delays.
        rand_mode = 1'b1;
        for (int t = 0; t < 2; t++) begin
            begin_load(25'($urandom), 13'($urandom));
            wait_done("random", 20000);
            end_load("random", 0);
        end
        rand_mode = 1'b0;
        step(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sdram_line_reader.md
SDRAM_LINE_READER -- requirements
Module: sdram_line_reader

Interface
REQ-001 Parameter WORDS_PER_LINE, default 512, meaning 16-bit SDRAM words per video line (2 pixels per word).
REQ-002 Parameter MAX_PENDING, default 8, meaning the credit limit: the maximum of (reads in flight + words held in the internal buffer); power of two, 2..32.
REQ-003 Port iCLK  in  1  sole clock; this is the SDRAM controller clock.
REQ-004 Port iRST  in  1  reset, synchronous and active-high.
REQ-005 Port iLOAD_REQ  in  1  single-cycle request to load one line.
REQ-006 Port iLINE  in  13  line index to load.
REQ-007 Port iFRAME_BASE  in  25  word address of line 0 of the frame.
REQ-008 Port oRD_EN  out  1  Avalon-MM read request.
REQ-009 Port oRD_ADDR  out  25  Avalon-MM read word address.
REQ-010 Port iWAIT_REQUEST  in  1  Avalon-MM waitrequest.
REQ-011 Port iRD_DATA  in  16  Avalon-MM readdata.
REQ-012 Port iRD_DATAVALID  in  1  Avalon-MM readdatavalid.
REQ-013 Port oWDATA  out  8  pixel byte to the VGA line FIFO.
REQ-014 Port oWEN  out  1  VGA line FIFO write enable.
REQ-015 Port iFIFO_FULL  in  1  VGA line FIFO full flag (write side).
REQ-016 Port oBUSY  out  1  high while a line load is in progress.
REQ-017 Port oDONE  out  1  one-cycle pulse when a line load completes.
REQ-018 Port oMISSED  out  1  one-cycle pulse when iLOAD_REQ is ignored because the block is busy.

Function
REQ-019 States: IDLE, READ, FLUSH; the FSM leaves IDLE only on iLOAD_REQ.
REQ-020 IDLE: on iLOAD_REQ, latch start = (iFRAME_BASE + iLINE*WORDS_PER_LINE) mod 2^25, clear the issued/received/emitted counters, set oBUSY, and enter READ on the next cycle.
REQ-021 Word k of the line (k = 0..WORDS_PER_LINE-1) is read from address (start + k) mod 2^25; at 2^25-1 the address wraps to 0.
REQ-022 READ: the block asserts oRD_EN only if issued < WORDS_PER_LINE and pending + buffered < MAX_PENDING.
REQ-023 A read is accepted in a cycle with oRD_EN=1 and iWAIT_REQUEST=0; issued and pending then increment.
REQ-024 While oRD_EN=1 and iWAIT_REQUEST=1, oRD_EN and oRD_ADDR hold stable; once asserted, oRD_EN is never withdrawn before acceptance.
REQ-025 Back-to-back acceptance: when credit remains, consecutive cycles issue consecutive addresses without a gap.
REQ-026 On iRD_DATAVALID=1 in READ or FLUSH, iRD_DATA is pushed into the internal word buffer (depth MAX_PENDING) and pending decrements; same-cycle accept and return are handled net, with no lost count.
REQ-027 Byte emission: each buffered word yields two FIFO writes, iRD_DATA[7:0] first, then [15:8]; at most one byte per cycle.
REQ-028 oWEN=1 only when a byte is available and iFIFO_FULL=0; if iFIFO_FULL=1, oWEN=0 and the same byte is retried with oWDATA held.
REQ-029 When issued reaches WORDS_PER_LINE, READ goes to FLUSH.
REQ-030 FLUSH: when pending=0, the buffer is empty and the final high byte is written, go to IDLE, pulse oDONE for one cycle and drop oBUSY in that same cycle.
REQ-031 iLOAD_REQ while oBUSY=1 is ignored (latched state unchanged) and pulses oMISSED the next cycle.
REQ-032 iLOAD_REQ in the same cycle as oDONE is ignored and pulses oMISSED.
REQ-033 iRD_DATAVALID received in IDLE is discarded with no oWEN.
REQ-034 Total output per load: exactly 2*WORDS_PER_LINE oWEN pulses, in address order.
REQ-035 Counter widths are sized to hold WORDS_PER_LINE and MAX_PENDING without overflow.

Reset
REQ-036 iRST=1 at any clock edge (including mid-load) forces IDLE, clears counters and the buffer, and drives oRD_EN=0, oRD_ADDR=0, oWEN=0, oWDATA=0, oBUSY=0, oDONE=0, oMISSED=0.
REQ-037 iRST shall be the same reset that resets the SDRAM controller, so no stale read returns after reset; no oDONE pulse is generated for an aborted load.

Verification
REQ-038 Base load: iFRAME_BASE=0, iLINE=3, WORDS_PER_LINE=512, iWAIT_REQUEST=0, 2-cycle read latency -> addresses 1536..2047, 1024 bytes low byte first, a single oDONE pulse.
REQ-039 Wait states: iWAIT_REQUEST held high for 5 cycles on the first read -> oRD_EN/oRD_ADDR=1536 stable all 5 cycles, no duplicate or skipped address.
REQ-040 Credit limit: readdatavalid withheld -> exactly MAX_PENDING=8 reads accepted, then oRD_EN=0 until data returns.
REQ-041 FIFO backpressure: iFIFO_FULL high for 10 cycles mid-line -> oWEN=0 throughout, oWDATA held, byte sequence intact afterwards, still 1024 writes.
REQ-042 Wrap and busy: iFRAME_BASE=0x1FFFF00, iLINE=0 -> addresses wrap after 0x1FFFFFF to 0x0000000; a second iLOAD_REQ mid-load -> oMISSED pulse and no effect on the load.
REQ-043 Reset mid-load: iRST pulsed after 100 bytes -> all outputs 0 the next cycle, no oDONE; a new load afterwards completes normally.
